// File: rtl/bcd7_scan_driver.sv
// bcd7_scan_driver: time-multiplexed N-digit 7-segment scan driver with frame-aligned data capture.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  hex_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);
  localparam logic SL = SEG_ACTIVE_LOW != 0;
  localparam logic AL = AN_ACTIVE_LOW != 0;
  localparam logic [6:0] LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] stg_q, stg_d, shd_q, shd_d;
  logic [DIGITS-1:0]   tdp_q, tdp_d, sdp_q, sdp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                tick, wrap, blank;
  logic [3:0]          nib;
  always_comb begin
    tick   = div_q == DMAX;
    wrap   = tick && idx_q == LAST;
    div_d  = tick ? '0 : div_q + 1'b1;
    idx_d  = !tick ? idx_q : wrap ? '0 : idx_q + 1'b1;
    stg_d  = load ? din : stg_q;
    tdp_d  = load ? dp_in : tdp_q;
    pend_d = wrap ? 1'b0 : pend_q | load;
    shd_d  = wrap && (pend_q || load) ? stg_d : shd_q;
    sdp_d  = wrap && (pend_q || load) ? tdp_d : sdp_q;
    nib    = shd_d[4*idx_d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank  = idx_d != '0 && (shd_d >> (4*idx_d)) == '0;
`else
    blank  = 1'b0;
`endif
    // outputs are computed for the slot being entered, from the shadow it will show
    seg_d  = (blank || (!hex_en && nib > 4'd9) ? 7'b0 : LUT[nib]) ^ {7{SL}};
    dp_d   = sdp_d[idx_d] ^ SL;
    an_d   = (DIGITS'(1) << idx_d) ^ {DIGITS{AL}};
    frame_start = wrap;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      idx_q  <= LAST;
      pend_q <= 1'b0;
      stg_q  <= '0;
      shd_q  <= '0;
      tdp_q  <= '0;
      sdp_q  <= '0;
      seg_q  <= {7{SL}};
      dp_q   <= SL;
      an_q   <= {DIGITS{AL}};
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      stg_q  <= stg_d;
      shd_q  <= shd_d;
      tdp_q  <= tdp_d;
      sdp_q  <= sdp_d;
      if (tick) begin
        seg_q <= seg_d;
        dp_q  <= dp_d;
        an_q  <= an_d;
      end
    end
  end
  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;
endmodule

// File: tb/tb_bcd7_scan_driver.sv
// tb_bcd7_scan_driver: random and directed checks of bcd7_scan_driver against a frame-level model.
module tb_bcd7_scan_driver;
  localparam int D = 4, SD = 4;
  logic clk = 0, rst_n = 0, load = 0, hex_en = 0;
  logic [15:0] din = 0;
  logic [3:0] dp_in = 0, an, an2;
  logic [6:0] seg, seg2;
  logic dp, dp2, fs, fs2;
  int n_cmp = 0, n_bad = 0;
  int cnt;
  bit pend, wrapped;
  logic [15:0] stg, shw;
  logic [3:0] sdp_s, shw_dp, e_an;
  logic [6:0] e_seg;
  logic e_dp;
  logic hx;
  logic [6:0] tbl [16] = '{7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
                           7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47};
  always #5 clk = ~clk;
  bcd7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dp_in(dp_in), .load(load), .hex_en(hex_en),
    .seg(seg), .dp(dp), .an(an), .frame_start(fs));
  bcd7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .dp_in(dp_in), .load(load), .hex_en(hex_en),
    .seg(seg2), .dp(dp2), .an(an2), .frame_start(fs2));
  function automatic logic [6:0] ref_seg(input logic [15:0] w, input int d, input logic h);
    int n;
    n = int'((w >> (4*d)) & 16'hf);
    if (!h && n >= 10) return 7'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (w >> (4*d)) == 16'h0) return 7'b0;
`endif
    return tbl[n];
  endfunction
  function automatic bit fs_now();
    return cnt % SD == SD - 1 && (cnt / SD) % D == 0;
  endfunction
  task automatic model_reset();
    cnt = 0; pend = 0; wrapped = 0; stg = 0; shw = 0; sdp_s = 0; shw_dp = 0;
    e_seg = 0; e_dp = 0; e_an = 0;
  endtask
  task automatic cyc(input logic l, input logic [15:0] d, input logic [3:0] p, input logic h);
    bit t, w;
    int dig;
    load = l; din = d; dp_in = p; hex_en = h;
    t = cnt % SD == SD - 1;
    dig = (cnt / SD) % D;
    w = t && dig == 0;
    if (l) begin stg = d; sdp_s = p; pend = 1; end
    if (w) begin
      if (pend) begin shw = stg; shw_dp = sdp_s; end
      pend = 0;
    end
    if (t) begin e_seg = ref_seg(shw, dig, h); e_dp = shw_dp[dig]; e_an = 4'(1 << dig); end
    wrapped = w;
    cnt++;
    @(posedge clk); #1;
  endtask
  task automatic idle();
    cyc(0, 16'($urandom), 4'($urandom), hx);
  endtask
  task automatic wait_wrap();
    int i;
    for (i = 0; i < 40 && !wrapped; i++) idle();
    n_cmp++;
    if (!wrapped) begin n_bad++; $display("FAIL wait_wrap: no wrap within %0d cycles", i); end
  endtask
  task automatic test_reset();
    repeat (12) idle();
    n_cmp++;
    if (an !== 4'b0100) begin n_bad++; $display("FAIL pre_reset_an: got %b want 0100", an); end
    rst_n = 0; #1;
    n_cmp++;
    if ({seg, an, dp, fs} !== 13'b0) begin
      n_bad++; $display("FAIL reset_outs: seg=%b an=%b dp=%b fs=%b want all 0", seg, an, dp, fs);
    end
    n_cmp++;
    if (seg2 !== 7'h7f || an2 !== 4'hf || dp2 !== 1'b1) begin
      n_bad++; $display("FAIL reset_inv: seg=%b an=%b dp=%b want 1111111 1111 1", seg2, an2, dp2);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    repeat (3) idle();
    n_cmp++;
    if (an !== 4'b0000) begin n_bad++; $display("FAIL early_tick: an=%b want 0000", an); end
    idle();
    n_cmp++;
    if (an !== 4'b0001 || seg !== 7'b1111110) begin
      n_bad++; $display("FAIL first_tick: an=%b seg=%b want 0001 1111110", an, seg);
    end
  endtask
  task automatic test_directed();
    logic [6:0] es [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    int pulses;
    hx = 1;
    cyc(1, 16'h1234, 4'b0100, hx);
    wait_wrap();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (SD) idle();
      n_cmp++;
      if (seg !== es[k] || an !== 4'(1 << k) || dp !== (k == 2)) begin
        n_bad++;
        $display("FAIL d1234_dig%0d: seg=%b an=%b dp=%b want %b %b %b", k, seg, an, dp, es[k], 4'(1 << k), k == 2);
      end
    end
    pulses = 0;
    repeat (16) begin idle(); pulses += int'(fs); end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL fs_rate: got %0d pulses want 1", pulses); end
  endtask
  task automatic test_hex();
    hx = 1;
    cyc(1, 16'h00af, 4'b0000, hx);
    wait_wrap();
    n_cmp++;
    if (seg !== 7'b1000111) begin n_bad++; $display("FAIL hex_F: got %b want 1000111", seg); end
    repeat (SD) idle();
    n_cmp++;
    if (seg !== 7'b1110111) begin n_bad++; $display("FAIL hex_A: got %b want 1110111", seg); end
    hx = 0;
    idle();
    wait_wrap();
    n_cmp++;
    if (seg !== 7'b0) begin n_bad++; $display("FAIL nohex_F: got %b want 0000000", seg); end
    repeat (SD) idle();
    n_cmp++;
    if (seg !== 7'b0) begin n_bad++; $display("FAIL nohex_A: got %b want 0000000", seg); end
  endtask
  task automatic test_back_to_back();
    int i;
    hx = 1;
    idle(); wait_wrap();
    cyc(1, 16'h1111, 4'b0, hx);
    idle();
    cyc(1, 16'h2222, 4'b0, hx);
    wait_wrap();
    n_cmp++;
    if (seg !== 7'b1101101) begin n_bad++; $display("FAIL last_load_wins: got %b want 1101101", seg); end
    for (i = 0; i < 40 && !fs_now(); i++) idle();
    n_cmp++;
    if (fs !== 1'b1) begin n_bad++; $display("FAIL fs_before_wrap: got %b want 1", fs); end
    cyc(1, 16'h3333, 4'b0001, hx);
    n_cmp++;
    if (seg !== 7'b1111001 || an !== 4'b0001 || dp !== 1'b1) begin
      n_bad++; $display("FAIL coincident_load: seg=%b an=%b dp=%b want 1111001 0001 1", seg, an, dp);
    end
  endtask
  task automatic test_blank();
    hx = 1;
    cyc(1, 16'h0007, 4'b0, hx);
    wait_wrap();
    n_cmp++;
    if (seg !== 7'b1110000) begin n_bad++; $display("FAIL blank_dig0: got %b want 1110000", seg); end
    for (int k = 1; k < 4; k++) begin
      repeat (SD) idle();
      n_cmp++;
`ifdef LEADING_ZERO_BLANK_EN
      if (seg !== 7'b0) begin n_bad++; $display("FAIL blank_dig%0d: got %b want 0000000", k, seg); end
`else
      if (seg !== 7'b1111110) begin n_bad++; $display("FAIL noblank_dig%0d: got %b want 1111110", k, seg); end
`endif
    end
    cyc(1, 16'h0000, 4'b0, hx);
    wait_wrap();
    n_cmp++;
    if (seg !== 7'b1111110) begin n_bad++; $display("FAIL zero_dig0: got %b want 1111110", seg); end
  endtask
  task automatic test_polarity();
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    hx = 1;
    cyc(1, 16'h8888, 4'b0, hx);
    wait_wrap();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (SD) idle();
      n_cmp++;
      if (seg2 !== 7'b0 || an2 !== ea[k]) begin
        n_bad++; $display("FAIL inv_8888_dig%0d: seg=%b an=%b want 0000000 %b", k, seg2, an2, ea[k]);
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 10) == 0, 16'($urandom), 4'($urandom), ($urandom % 4) != 0);
      n_cmp++;
      if (seg !== e_seg || an !== e_an || dp !== e_dp || fs !== fs_now()) begin
        n_bad++;
        $display("FAIL rand_%0d: seg=%b an=%b dp=%b fs=%b want %b %b %b %b", i, seg, an, dp, fs, e_seg, e_an, e_dp, fs_now());
      end
      n_cmp++;
      if (seg2 !== ~e_seg || an2 !== ~e_an || dp2 !== ~e_dp || fs2 !== fs_now()) begin
        n_bad++;
        $display("FAIL rand_inv_%0d: seg=%b an=%b dp=%b fs=%b want %b %b %b %b", i, seg2, an2, dp2, fs2, ~e_seg, ~e_an, ~e_dp, fs_now());
      end
    end
  endtask
  initial begin
    hx = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_directed();
    test_hex();
    test_back_to_back();
    test_blank();
    test_polarity();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
